tx8b10b_arbiter: RTL
====================

Name: tx8b10b_arbiter

Overview:
- Shares one 8b10b transmitter byte FIFO between NUM_REQ byte-stream requesters. Arbitration is round-robin and packet-granular.
- Generates the transmitter's bit-rate enable strobe.
- Paces FIFO writes so the registered full flag is always re-sampled before the next write.
- Sits between client logic and the Tx8b10b write port (dataIn/writeStrobe/full/en).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_RATE, 8, clocks per transmitted bit; period of txEnable (>=2).
- MAX_BURST, 16, maximum bytes per grant before forced rotation (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-low
- reqValid  input  NUM_REQ  per-requester byte valid
- reqData  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
- reqLast  input  NUM_REQ  byte is last of packet
- reqReady  output  NUM_REQ  byte accepted this cycle when reqValid&reqReady
- grant  output  NUM_REQ  one-hot current owner; all zero when idle
- busy  output  1  grant held
- txEnable  output  1  one-cycle strobe every CLK_RATE clocks, to transmitter en
- txDataIn  output  8  byte to transmitter FIFO
- txWriteStrobe  output  1  write pulse to transmitter FIFO
- txFull  input  1  transmitter FIFO full

Behaviour:
- Reset values (rst=0 at posedge):
  - all outputs 0; txDataIn=0.
  - state=IDLE, rr pointer=0, burst count=0, enable counter=CLK_RATE-1.
- Enable generator:
  - Counter decrements each clock. When it is 0, it reloads CLK_RATE-1 and txEnable=1 on the next cycle.
  - First txEnable pulse is CLK_RATE cycles after reset release; pulses then repeat exactly every CLK_RATE cycles.
  - Free-running; independent of arbitration.
- State machine IDLE / XFER / GAP:
  - IDLE: if any reqValid, select the first asserted index searching from the rr pointer upward with wrap. Register grant one-hot and go to XFER; burst count=0. No reqValid: stay.
  - XFER: reqReady[g] = grant[g] & ~txFull (combinational; only the granted bit may be 1).
    - On a beat (reqValid[g]&reqReady[g]), next cycle: txDataIn=reqData[g], txWriteStrobe=1 for exactly one cycle; burst count+1.
    - Beat with reqLast[g]=1, or burst count reaching MAX_BURST: grant released, rr pointer=g+1 mod NUM_REQ, go to IDLE. This transition coincides with the write cycle.
    - Otherwise a beat goes to GAP.
    - No beat (valid low or txFull): stay in XFER holding the grant; bubbles are allowed.
  - GAP: one cycle with reqReady=0 so the write is reflected in txFull; then back to XFER.
  - Maximum throughput is one byte per 2 clocks.
- Latency: reqValid rising in IDLE -> grant next cycle -> earliest reqReady that cycle -> txWriteStrobe one cycle later.
- Boundary cases:
  - txFull high in XFER stalls with the grant held.
  - A requester dropping reqValid mid-packet keeps its grant until reqLast or MAX_BURST.
  - Simultaneous requests resolve by rr order only.
  - Asserting rst mid-packet aborts the packet: no write is issued on the reset cycle and the pointer returns to 0.
- Widths: burst count is 8 bits, compared equal to MAX_BURST. rr pointer is clog2(NUM_REQ) bits and wraps at NUM_REQ-1 -> 0.

Optional Feature:
- Macro TX8B10B_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority in IDLE (wins whenever reqValid[0]=1, regardless of the rr pointer). Its grant does not advance the rr pointer. Other requesters use round-robin among themselves. MAX_BURST still applies to requester 0.
- Undefined: pure round-robin over all NUM_REQ.

Test Plan:
- Reset then idle, CLK_RATE=8 -> txEnable first high 8 cycles after release, then every 8 cycles; all other outputs 0.
- Req1 sends 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), txFull=0 -> grant=0010; writes 0xA1,0xA2,0xA3 on cycles spaced by 2; then IDLE and rr pointer=2.
- Req0 and req2 both valid continuously with 1-byte packets -> grants alternate 0001,0100,0001,...; each packet is written once.
- Req3 streams 20 bytes with no reqLast, MAX_BURST=16 -> exactly 16 writes, then grant drops; a pending req0 is granted next.
- txFull forced high after the 2nd byte for 10 cycles -> reqReady=0 and no txWriteStrobe during the stall; grant held; bytes 3+ resume in order with none lost or duplicated.
- rst=0 asserted mid-packet -> next cycle grant=0, txWriteStrobe=0; with macro defined, req0 wins over req1 with the pointer at 1.

Source files
------------

// File: rtl/tx8b10b_arbiter.sv
// Round-robin, packet-granular arbiter sharing one 8b10b Tx byte FIFO.
// Optional macro TX8B10B_ARB_PRIORITY_EN gives requester 0 strict priority.
module tx8b10b_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CLK_RATE  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]   reqLast,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 txEnable,
  output logic [7:0]           txDataIn,
  output logic                 txWriteStrobe,
  input  logic                 txFull
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CLK_RATE);
  localparam logic [CW-1:0] EN_LOAD = CW'(CLK_RATE - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] enCnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gIdx;
  logic [7:0]    burstCnt;

  logic          beat;
  logic [7:0]    selByte;
  logic          selLast;
  logic          pickHit;
  logic [PW-1:0] pickIdx;
  logic [PW-1:0] nextPtr;
  logic          endPkt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      enCnt    <= EN_LOAD;
      txEnable <= 1'b0;
    end else if (enCnt == '0) begin
      enCnt    <= EN_LOAD;
      txEnable <= 1'b1;
    end else begin
      enCnt    <= enCnt - 1'b1;
      txEnable <= 1'b0;
    end
  end

  always_comb begin
    reqReady = '0;
    if (state == XFER && !txFull)
      reqReady = grant;
  end

  assign beat = |(reqValid & reqReady);

  always_comb begin
    selByte = 8'h00;
    selLast = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gIdx == PW'(k)) begin
        selByte = reqData[8*k +: 8];
        selLast = reqLast[k];
      end
    end
  end

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    pickHit = 1'b0;
    pickIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef TX8B10B_ARB_PRIORITY_EN
      if (!pickHit && reqValid[(int'(ptr) + i) % NUM_REQ]
          && ((int'(ptr) + i) % NUM_REQ) != 0) begin
`else
      if (!pickHit && reqValid[(int'(ptr) + i) % NUM_REQ]) begin
`endif
        pickHit = 1'b1;
        pickIdx = PW'((int'(ptr) + i) % NUM_REQ);
      end
    end
`ifdef TX8B10B_ARB_PRIORITY_EN
    if (reqValid[0]) begin
      pickHit = 1'b1;
      pickIdx = '0;
    end
`endif
  end

  always_comb begin
    nextPtr = (gIdx == LAST_IDX) ? '0 : gIdx + 1'b1;
`ifdef TX8B10B_ARB_PRIORITY_EN
    if (gIdx == '0)
      nextPtr = ptr;
`endif
  end

  assign endPkt = selLast || (burstCnt + 8'd1 == BURST_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      grant         <= '0;
      busy          <= 1'b0;
      gIdx          <= '0;
      ptr           <= '0;
      burstCnt      <= 8'h00;
      txDataIn      <= 8'h00;
      txWriteStrobe <= 1'b0;
    end else begin
      txWriteStrobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pickHit) begin
            grant    <= ONE << pickIdx;
            busy     <= 1'b1;
            gIdx     <= pickIdx;
            burstCnt <= 8'h00;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            txDataIn      <= selByte;
            txWriteStrobe <= 1'b1;
            burstCnt      <= burstCnt + 8'd1;
            if (endPkt) begin
              grant <= '0;
              busy  <= 1'b0;
              ptr   <= nextPtr;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        // Lets the registered full flag see the write just issued
        GAP: state <= XFER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
